// File: rtl/swu_pkg.sv
// Shared constants and FSM state type for the sliding-window unit ECG word writer.
package swu_pkg;
    localparam int DEPTH = 29;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int IN_W  = 2;
    localparam int CPW   = DW / IN_W;
    localparam int CW    = (CPW > 1) ? $clog2(CPW) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} swu_wr_state_t;
endpackage

// File: rtl/swu_pack_wr_if.sv
// Chunk stream in, RAM write port out; slave side belongs to the packer.
interface swu_pack_wr_if;
    import swu_pkg::*;

    logic            valid;
    logic [IN_W-1:0] data;
    logic            last;
    logic            ready;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;

    modport slave  (input valid, data, last, output ready, we, addr, wdata);
    modport master (output valid, data, last, input ready, we, addr, wdata);
endinterface

// File: rtl/swu_word_packer.sv
// MSB-first chunk shift register; provides the completed word and a left-justified padded partial word.
module swu_word_packer
    import swu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            acc_i,
    input  logic [IN_W-1:0] data_i,
    output logic            word_ready_o,
    output logic [DW-1:0]   full_word_o,
    output logic [DW-1:0]   pad_word_o
);
    logic [DW-1:0] sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   rem;

    assign full_word_o  = {sreg_q[DW-IN_W-1:0], data_i};
    assign word_ready_o = acc_i && (cnt_q == CW'(CPW - 1));
    // cnt_q chunks sit in the LSBs; shift the empty slots out to the bottom.
    assign rem          = (CW+1)'(CPW) - {1'b0, cnt_q};
    assign pad_word_o   = sreg_q << (rem * IN_W);

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clr_i || word_ready_o) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (acc_i) begin
            sreg_d = full_word_o;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/swu_pack_wr.sv
// Packs an ECG chunk stream into DW-bit words and writes them to the frame buffer RAM from address 0.
module swu_pack_wr
    import swu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    swu_pack_wr_if.slave  bus,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic [AW:0]   word_cnt_o,
    output logic          overflow_o
);
    swu_wr_state_t state_q;
    logic [AW-1:0] addr_q, ram_addr_q;
    logic [AW:0]   wcnt_q;
    logic [DW-1:0] wdata_q;
    logic          ram_we_q, done_q, ovf_q;
    logic          acc, clr, word_ready;
    logic [DW-1:0] full_word, pad_word;

    assign bus.ready    = (state_q == FILL);
    assign acc          = bus.ready && bus.valid;
    assign clr          = (state_q == IDLE) && start_i;
    assign bus.we       = ram_we_q;
    assign bus.addr     = ram_addr_q;
    assign bus.wdata    = wdata_q;
    assign busy_o       = (state_q == FILL) || (state_q == FLUSH);
    assign frame_done_o = done_q;
    assign word_cnt_o   = wcnt_q;
    assign overflow_o   = ovf_q;

    swu_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .acc_i        (acc),
        .data_i       (bus.data),
        .word_ready_o (word_ready),
        .full_word_o  (full_word),
        .pad_word_o   (pad_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ram_addr_q <= '0;
            wcnt_q     <= '0;
            wdata_q    <= '0;
            ram_we_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    addr_q  <= '0;
                    wcnt_q  <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= FILL;
                end
                FILL: if (acc) begin
                    if (word_ready) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        wdata_q    <= full_word;
                        addr_q     <= addr_q + 1'b1;
                        wcnt_q     <= wcnt_q + 1'b1;
                        if (bus.last) begin
                            state_q <= DONE;
                        end else if (addr_q == AW'(DEPTH - 1)) begin
                            state_q <= DONE;
                            ovf_q   <= 1'b1;
                        end
                    end else if (bus.last) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= addr_q;
                    wdata_q    <= pad_word;
                    addr_q     <= addr_q + 1'b1;
                    wcnt_q     <= wcnt_q + 1'b1;
                    state_q    <= DONE;
                end
                // Pulse lands in the cycle after the final write in every path.
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/swu_pack_wr.md
Name: swu_pack_wr

Overview:
- Write-side counterpart of the sliding-window unit's ECG word store.
- Accepts a stream of IN_W-bit chunks and packs them MSB-first into DW-bit words, so the first chunk of a frame lands in bits [DW-1:DW-IN_W].
- Writes the packed words to consecutive addresses of a DEPTH-word single-port RAM that the sliding-window reader later scans from address 0.
- Sits between the ECG sample front-end and the ECG buffer RAM, and signals frame completion to the controller.

Parameters:
- DEPTH, 29, number of RAM words per frame.
- AW, 5, RAM address width; must satisfy 2^AW >= DEPTH.
- DW, 32, RAM word width.
- IN_W, 2, chunk width; must divide DW. CPW = DW/IN_W chunks per word (16 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  pulse; begins a new frame. Honoured only in IDLE.
- in_valid  in  1  chunk valid.
- in_data  in  IN_W  chunk payload.
- in_last  in  1  qualifies the final chunk of the frame.
- in_ready  out  1  chunk accepted when in_valid && in_ready.
- ram_we  out  1  RAM write strobe (registered).
- ram_addr  out  AW  RAM write address (registered).
- ram_wdata  out  DW  RAM write data (registered).
- busy  out  1  high in FILL and FLUSH.
- frame_done  out  1  one-cycle completion pulse.
- word_cnt  out  AW+1  words written in the current or last frame.
- overflow  out  1  sticky error: frame hit DEPTH words without in_last.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, shift register, chunk count and address all 0. Reset mid-frame aborts the frame; no ram_we is issued after reset asserts.
- FSM states: IDLE, FILL, FLUSH, DONE.
- IDLE:
  - in_ready = 0.
  - On start: clear word_cnt, address, chunk count and overflow, then go to FILL.
  - A chunk presented in the same cycle as start is not accepted.
- FILL:
  - in_ready = 1; one chunk per cycle at full throughput.
  - On each accepted chunk: sreg <= {sreg[DW-IN_W-1:0], in_data}; chunk count increments.
- Word completion (chunk count reaches CPW-1 and a chunk is accepted):
  - Next cycle: ram_we = 1, ram_wdata = the completed word, ram_addr = current address.
  - Address and word_cnt increment. sreg and chunk count clear in the same edge, so there is no stall.
- in_last accepted with a partial word (k < CPW chunks in the word):
  - Go to FLUSH. The word is left-justified and zero-padded: the k chunks occupy the MSBs and the LSBs are 0.
  - FLUSH issues that single write next cycle, then goes to DONE.
- in_last accepted on a word-completing chunk: normal write, no extra padded word, go to DONE.
- Capacity: when the DEPTH-th word completes without in_last, go to DONE and set overflow. in_ready drops in the cycle after that accepting edge.
- DONE: in_ready = 0, frame_done = 1 for exactly one cycle, then IDLE.
- Timing of frame_done: it coincides with the cycle after the final ram_we.
- word_cnt holds its value until the next start.
- start outside IDLE is ignored.
- in_data is ignored when in_valid = 0, or when in_valid = 1 with in_ready = 0.
- ram_we never asserts in IDLE or DONE, and at most once per cycle.
- ram_addr never exceeds DEPTH-1.

Decomposition:
- Shared package swu_pkg holds:
  - constants DEPTH, AW, DW, IN_W and derived CPW;
  - the FSM state enum swu_wr_state_t.
- One natural sub-module: swu_word_packer, containing the shift register, chunk counter, left-justify/pad logic and word_ready output.
- swu_pack_wr holds the FSM, address/word counters and the registered RAM port.

Test Plan:
- Full words: start, then 16 chunks of 2'b01 followed by 16 chunks of 2'b11, back-to-back → ram_we at addr 0 with data 0x55555555, then addr 1 with 0xFFFFFFFF. Each write lands 1 cycle after its 16th chunk; in_ready stays high throughout.
- Partial word: start, then chunks 2'b10, 2'b11, 2'b01 with in_last on the third → single write at addr 0 with data 0xB4000000; frame_done next cycle; word_cnt = 1; overflow = 0.
- Capacity: 464 chunks of 2'b10 with no in_last → 29 writes of 0xAAAAAAAA to addrs 0..28; in_ready = 0 after the 464th chunk; frame_done pulses; overflow = 1; word_cnt = 29.
- in_last on a word boundary: 32 chunks with in_last on the 32nd → exactly 2 writes, no padded third write, frame_done once.
- Backpressure and ignore rules:
  - in_valid toggling every other cycle inside a word → identical data to the contiguous case.
  - start asserted during FILL → no effect.
  - Chunks offered in IDLE → never written.
- Reset mid-frame: rst high after 10 chunks → all outputs 0 immediately, no write. A new start then produces a word at addr 0 built only from post-reset chunks.
